mem_rd_stream: RTL and testbench
================================

MEM_RD_STREAM -- requirements
Module: mem_rd_stream

Interface
REQ-001 SHALL have parameter ROWLENGTH, default 128, pixels per row.
REQ-002 SHALL have parameter NUMROWS, default 96, rows per frame.
REQ-003 SHALL have parameter BRAM_DEPTH, default 16384, line-buffer depth in words; AW = clog2(BRAM_DEPTH).
REQ-004 SHALL have ports, clock and reset first:
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_waddr  in  AW  writer's next-write address; valid words occupy [o_raddr, i_waddr) modulo BRAM_DEPTH.
- o_raddr  out  AW  BRAM read address.
- o_rd  out  1  BRAM read enable.
- i_rdata  in  12  BRAM read data, valid exactly 1 cycle after o_rd.
- o_data  out  12  output pixel.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts; transfer = o_valid && i_ready.
- o_sol / o_eol  out  1  first / last pixel of a row, qualified by o_valid.
- o_sof / o_eof  out  1  first / last pixel of a frame, qualified by o_valid.
- o_busy  out  1  high in state ROW.

Function
REQ-010 SHALL compute occupancy = (i_waddr - o_raddr) mod BRAM_DEPTH at AW bits; wrap is modular, no sign bit.
REQ-011 SHALL implement states IDLE and ROW.
REQ-012 IDLE -> ROW when occupancy >= ROWLENGTH; issue counter cleared on entry.
REQ-013 In ROW, SHALL assert o_rd for one cycle when issued < ROWLENGTH and (queued + in_flight) < 2; same edge increments o_raddr, wrapping BRAM_DEPTH-1 -> 0.
REQ-014 ROW -> IDLE on the cycle the ROWLENGTH-th read is issued; the next row starts no earlier than the following cycle, and only if REQ-012 holds.
REQ-015 SHALL hold read data in a 2-entry output queue (output register plus skid register); returned data is never dropped or duplicated under any i_ready pattern.
REQ-016 o_valid SHALL be high whenever the queue is non-empty; o_data and flags SHALL stay stable while o_valid && !i_ready.
REQ-017 Minimum latency, o_rd to o_valid with i_ready high: 2 cycles. Sustained throughput: 1 pixel/cycle.
REQ-018 SHALL tag each pixel with column count (0..ROWLENGTH-1) and row count (0..NUMROWS-1), both advancing on transfer.
- o_sol: col==0. o_eol: col==ROWLENGTH-1.
- o_sof: col==0 && row==0. o_eof: o_eol && row==NUMROWS-1.
- Row count wraps to 0 after NUMROWS-1.
REQ-019 i_ready low SHALL stall issue via REQ-013 only; the FSM does not exit ROW early.
REQ-020 occupancy == 0 SHALL never be treated as full.
REQ-021 Overrun by the writer is not detected; upstream sizing prevents it.

Reset
REQ-030 While i_rstn is low, SHALL asynchronously force:
- state=IDLE; o_raddr=0; o_rd=0; o_valid=0; queue empty; o_data=0.
- all flags=0; row and column counts=0; o_busy=0.
REQ-031 Reset asserted mid-row SHALL discard the partial row and queued data; after release, output resumes at address 0 with o_sof.
REQ-032 Reset release SHALL be synchronised externally; the block adds no synchroniser.

Structure
REQ-040 ROWLENGTH, NUMROWS, BRAM_DEPTH defaults and pixel width 12 SHALL live in the shared video parameters package, used by both the BRAM writer and this block.
REQ-041 The 2-entry queue SHALL be sub-module skid_buf (parameter WIDTH = 12+4 flag bits); FSM and counters stay in mem_rd_stream.

Verification
REQ-050 Writer fills 128 words at addr 0..127, i_ready=1 -> o_rd high for 128 consecutive cycles; o_valid 2 cycles after first o_rd; 128 pixels in order; o_sol+o_sof on pixel 0, o_eol on pixel 127.
REQ-051 127 words present -> stays IDLE, o_rd=0; 128th word written -> ROW within 1 cycle.
REQ-052 i_ready toggled randomly (50%) over 3 rows -> 384 pixels, no loss or duplication, data stable during stalls, at most 2 outstanding reads.
REQ-053 Start o_raddr at 16320 with 128 words wrapping -> addresses 16320..16383 then 0..63; data contiguous.
REQ-054 96 rows streamed -> o_eof on pixel 127 of row 95; next pixel carries o_sof.
REQ-055 i_rstn pulsed low at pixel 60 of a row -> all outputs 0 within the reset cycle without a clock edge; next row restarts at address 0 with o_sof.

Source files
------------

// File: rtl/mem_rd_stream_pkg.sv
// Video parameters shared by the BRAM line writer and the line reader.
// Also holds the pixel bundle carried through the reader's output queue.
package mem_rd_stream_pkg;

    localparam int PIX_W          = 12;
    localparam int FLAG_W         = 4;
    localparam int ROWLENGTH_DEF  = 128;
    localparam int NUMROWS_DEF    = 96;
    localparam int BRAM_DEPTH_DEF = 16384;

    typedef enum logic {
        IDLE = 1'b0,
        ROW  = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic             sof;
        logic             eof;
        logic             sol;
        logic             eol;
        logic [PIX_W-1:0] data;
    } pix_t;

endpackage

// File: rtl/mem_rd_stream_skid_buf.sv
// Two-entry output queue: an output register backed by one skid register.
// The producer only pushes when it has reserved space, so there is no full flag.
module skid_buf #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic             out_vld_q, out_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             pop;

    assign pop = out_vld_q & i_ready;

    // Refill the output register from skid first, then from the input.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_d      = skid_q;
                skid_vld_d = i_push;
                if (i_push) skid_d = i_data;
            end else begin
                out_vld_d = i_push;
                if (i_push) out_d = i_data;
            end
        end else if (i_push) begin
            skid_vld_d = 1'b1;
            skid_d     = i_data;
        end
    end

    // Queue registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign o_valid = out_vld_q;
    assign o_data  = out_q;
    assign o_count = {1'b0, out_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: rtl/mem_rd_stream.sv
// Streams complete rows out of a circular BRAM line buffer as tagged pixels.
// Reads are only issued when the 2-entry output queue has a reserved slot.
module mem_rd_stream
    import mem_rd_stream_pkg::*;
#(
    parameter int ROWLENGTH  = ROWLENGTH_DEF,
    parameter int NUMROWS    = NUMROWS_DEF,
    parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
    localparam int AW        = $clog2(BRAM_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [AW-1:0]    i_waddr,
    output logic [AW-1:0]    o_raddr,
    output logic             o_rd,
    input  logic [PIX_W-1:0] i_rdata,
    output logic [PIX_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sol,
    output logic             o_eol,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_busy
);

    localparam int IW = $clog2(ROWLENGTH + 1);
    localparam int CW = $clog2(ROWLENGTH);
    localparam int RW = $clog2(NUMROWS);

    localparam logic [AW:0]   RL_OCC    = (AW+1)'(ROWLENGTH);
    localparam logic [IW-1:0] RL_ISS    = IW'(ROWLENGTH);
    localparam logic [IW-1:0] LAST_ISS  = IW'(ROWLENGTH - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(ROWLENGTH - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(NUMROWS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);

    rd_state_e     state_q, state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [IW-1:0] issued_q, issued_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          inflight_q;
    logic [AW-1:0] occ;
    logic [1:0]    q_count;
    logic [1:0]    load;
    logic          q_valid;
    logic          rd;
    pix_t          pix_in;
    pix_t          pix_out;

    // Modular fill level; zero always means empty.
    assign occ  = i_waddr - raddr_q;
    // Slots held after this cycle's pop; a new read needs one free.
    assign load = q_count + {1'b0, inflight_q}
                - {1'b0, q_valid & i_ready};
    assign rd   = (state_q == ROW) && (issued_q < RL_ISS)
                && (load < 2'd2);

    // Row FSM, issue counter and read address.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        raddr_d  = raddr_q;
        unique case (state_q)
            IDLE: begin
                if ({1'b0, occ} >= RL_OCC) begin
                    state_d  = ROW;
                    issued_d = '0;
                end
            end
            ROW: begin
                if (rd) begin
                    issued_d = issued_q + IW'(1);
                    raddr_d  = (raddr_q == LAST_ADDR) ? '0
                             : raddr_q + AW'(1);
                    if (issued_q == LAST_ISS) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag returning words; queue order equals transfer order.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (inflight_q) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        pix_in.data = i_rdata;
        pix_in.sol  = (col_q == '0);
        pix_in.eol  = (col_q == LAST_COL);
        pix_in.sof  = (col_q == '0) && (row_q == '0);
        pix_in.eof  = (col_q == LAST_COL) && (row_q == LAST_ROW);
    end

    // State, address, counters and read-return tracking.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            raddr_q    <= '0;
            issued_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            issued_q   <= issued_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= rd;
        end
    end

    skid_buf #(
        .WIDTH (PIX_W + FLAG_W)
    ) u_q (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (inflight_q),
        .i_data  (pix_in),
        .i_ready (i_ready),
        .o_valid (q_valid),
        .o_data  (pix_out),
        .o_count (q_count)
    );

    assign o_raddr = raddr_q;
    assign o_rd    = rd;
    assign o_valid = q_valid;
    assign o_data  = pix_out.data;
    assign o_sol   = pix_out.sol;
    assign o_eol   = pix_out.eol;
    assign o_sof   = pix_out.sof;
    assign o_eof   = pix_out.eof;
    assign o_busy  = (state_q == ROW);

endmodule

// File: tb/tb_mem_rd_stream.sv
// Directed bench for mem_rd_stream with a BRAM model and pixel scoreboard.
// Covers reset, row start threshold, stalls, frame end, wrap and mid-row reset.
module tb_mem_rd_stream;
    import mem_rd_stream_pkg::*;

    localparam int RL    = 128;
    localparam int NR    = 96;
    localparam int DEPTH = 16384;
    localparam int AW    = 14;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          rd;
    logic [11:0]   rdata;
    logic [11:0]   data;
    logic          valid;
    logic          ready;
    logic          sol, eol, sof, eof, busy;

    logic [11:0]   mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_rd_stream #(
        .ROWLENGTH  (RL),
        .NUMROWS    (NR),
        .BRAM_DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_waddr (waddr),
        .o_raddr (raddr),
        .o_rd    (rd),
        .i_rdata (rdata),
        .o_data  (data),
        .o_valid (valid),
        .i_ready (ready),
        .o_sol   (sol),
        .o_eol   (eol),
        .o_sof   (sof),
        .o_eof   (eof),
        .o_busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // BRAM model: one-cycle read latency.
    always @(posedge clk) if (rd) rdata <= mem[raddr];

    initial begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] = 12'(i * 37 + (i >> 12) * 1111 + 5);
    end

    // Scoreboard state.
    int          exp_addr = 0, iss_addr = 0;
    int          exp_col = 0, exp_row = 0;
    int          n_iss = 0, n_xfer = 0;
    int          eof_cnt = 0, eof_at = -1;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_pack = '0;
    logic        xfer;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_addr = 0; iss_addr = 0; exp_col = 0; exp_row = 0;
            n_iss = 0; n_xfer = 0; eof_cnt = 0; eof_at = -1;
            prev_stall = 1'b0;
        end else begin
            xfer = valid && ready;
            if (rd) begin
                check("raddr", raddr, iss_addr);
                check("outstanding",
                      (n_iss - n_xfer - (xfer ? 1 : 0) + 1) <= 2, 1);
                iss_addr = (iss_addr + 1) % DEPTH;
                n_iss++;
            end
            if (prev_stall)
                check("stall_hold", {valid, data, sof, eof, sol, eol},
                      prev_pack);
            if (xfer) begin
                check("pixel", {data, sof, eof, sol, eol},
                      {mem[exp_addr],
                       exp_col == 0 && exp_row == 0,
                       exp_col == RL - 1 && exp_row == NR - 1,
                       exp_col == 0,
                       exp_col == RL - 1});
                if (eof) begin eof_cnt++; eof_at = n_xfer; end
                exp_addr = (exp_addr + 1) % DEPTH;
                if (exp_col == RL - 1) begin
                    exp_col = 0;
                    exp_row = (exp_row == NR - 1) ? 0 : exp_row + 1;
                end else begin
                    exp_col++;
                end
                n_xfer++;
            end
            prev_stall = valid && !ready;
            prev_pack  = {valid, data, sof, eof, sol, eol};
        end
    end

    task automatic run_until(input int target, input int budget,
                             input bit rnd, input string tag);
        for (int k = 0; k < budget && n_xfer < target; k++) begin
            @(posedge clk); #1;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        ready = 1'b1;
        repeat (8) @(negedge clk);
        check(tag, n_xfer, target);
        check({tag, "_drained"}, {valid, busy}, 2'b00);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_rd"}, rd, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_flags"}, {sof, eof, sol, eol}, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    int run;

    initial begin
        rstn  = 1'b0;
        waddr = '0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;

        // 127 words: below threshold.
        @(posedge clk); #1;
        waddr = 14'd127;
        repeat (6) @(negedge clk);
        check("idle127_busy", busy, 0);
        check("idle127_rd", rd, 0);

        // 128th word starts the row on the next edge.
        @(posedge clk); #1;
        waddr = 14'd128;
        @(posedge clk);
        @(negedge clk);
        check("row_start_busy", busy, 1);
        check("row_start_rd", rd, 1);
        run = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 1) check("lat_c1", valid, 0);
            if (i == 2) check("lat_c2", valid, 1);
            if (!rd) break;
            run++;
            @(negedge clk);
        end
        check("rd_run", run, RL);
        check("row_end_busy", busy, 0);
        run_until(RL, 300, 1'b0, "row1");

        // Three rows under random back-pressure.
        @(posedge clk); #1;
        waddr = 14'd512;
        run_until(512, 3000, 1'b1, "rand3");

        // Rest of the frame plus one row.
        @(posedge clk); #1;
        waddr = 14'd12416;
        run_until(12416, 14000, 1'b0, "frame");
        check("eof_cnt", eof_cnt, 1);
        check("eof_at", eof_at, NR * RL - 1);

        // Fill to the top of the buffer, then wrap past address 0.
        @(posedge clk); #1;
        waddr = 14'd16000;
        run_until(16000, 5000, 1'b0, "to_top");
        @(posedge clk); #1;
        waddr = 14'd256;
        run_until(16640, 1500, 1'b0, "wrap");
        check("wrap_raddr", raddr, 256);

        // Reset in the middle of a row.
        @(posedge clk); #1;
        waddr = 14'd384;
        for (int k = 0; k < 400 && n_xfer < 16700; k++) begin
            @(posedge clk); #1;
        end
        check("mid_row_valid", valid, 1);
        rstn = 1'b0;
        #1;
        check_zero("async_rst");
        waddr = 14'd128;
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        run_until(RL, 400, 1'b0, "post_rst");
        check("post_rst_raddr", raddr, 128);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
